// File: rtl/bus_xbar_pkg.sv
// Shared types and decode helper for the bus_xbar_ooo crossbar.
// Index widths are sized for the largest legal configuration so one entry type serves every build.
package bus_xbar_pkg;

  localparam int unsigned NrHostsMax   = 8;
  localparam int unsigned NrDevicesMax = 16;
  localparam int unsigned AddrWMax     = 64;

  localparam int unsigned HostIdxW = $clog2(NrHostsMax);
  localparam int unsigned DevIdxW  = $clog2(NrDevicesMax + 1);

  typedef struct packed {
    logic [HostIdxW-1:0] host;
    logic [DevIdxW-1:0]  dev;
    logic                decerr;
  } rsp_entry_t;

  // Single-window hit test; callers zero-extend narrower addresses.
  function automatic logic addr_decode(input logic [AddrWMax-1:0] addr,
                                       input logic [AddrWMax-1:0] base,
                                       input logic [AddrWMax-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_xbar_rsp_fifo.sv
// Synchronous FIFO tracking outstanding transactions in issue order.
// A push while full is accepted only together with a pop.
module bus_xbar_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [PtrW-1:0]             wptr_q, rptr_q;
  logic [CntW-1:0]             cnt_q;
  logic                        do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/bus_xbar_ooo.sv
// Multi-host / multi-device bus crossbar with pipelined in-order responses and DECERR generation.
// Define BUS_XBAR_RR_ARB_EN for round-robin arbitration; default is fixed priority (host 0 highest).
module bus_xbar_ooo
  import bus_xbar_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned NrDevices      = 3,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NrHosts-1:0]                       host_req_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrDevices-1:0]                     device_req_o,
  output logic [NrDevices-1:0]                     device_we_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0]                     device_err_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);

  localparam int unsigned HIW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DIW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

  logic             en_q;
  rsp_entry_t       head, push_ent;
  logic [HIW-1:0]   head_host, sel_host;
  logic [DIW-1:0]   head_dev, sel_dev;
  logic             fifo_full, fifo_empty, rsp_pop;
  logic [CntW-1:0]  fifo_cnt;
  logic             sel_vld, sel_hit, any_gnt;

  // Holds grants off while in reset so every output is zero asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) en_q <= 1'b0;
    else         en_q <= 1'b1;
  end

  assign head_host = HIW'(head.host);
  assign head_dev  = DIW'(head.dev);
  assign rsp_pop   = !fifo_empty && (head.decerr || device_rvalid_i[head_dev]);

  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    if (rsp_pop) begin
      host_rvalid_o[head_host] = 1'b1;
      host_err_o[head_host]    = head.decerr | device_err_i[head_dev];
      host_rdata_o[head_host]  = head.decerr ? '0 : device_rdata_i[head_dev];
    end
  end

`ifdef BUS_XBAR_RR_ARB_EN
  logic [HIW-1:0] ptr_q;
  logic [HIW:0]   idx;

  // Walk downward so the requester nearest the pointer is the last (winning) assignment.
  always_comb begin
    sel_vld  = 1'b0;
    sel_host = '0;
    idx      = '0;
    for (int k = NrHosts - 1; k >= 0; k--) begin
      idx = (HIW+1)'(ptr_q) + (HIW+1)'(k);
      if (idx >= (HIW+1)'(NrHosts)) idx = idx - (HIW+1)'(NrHosts);
      if (host_req_i[idx[HIW-1:0]]) begin
        sel_vld  = 1'b1;
        sel_host = idx[HIW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else if (any_gnt) ptr_q <= (32'(sel_host) == NrHosts - 1) ? '0 : sel_host + 1'b1;
  end
`else
  always_comb begin
    sel_vld  = 1'b0;
    sel_host = '0;
    for (int k = NrHosts - 1; k >= 0; k--) begin
      if (host_req_i[k]) begin
        sel_vld  = 1'b1;
        sel_host = HIW'(k);
      end
    end
  end
`endif

  assign any_gnt = en_q && sel_vld && (!fifo_full || rsp_pop);

  always_comb begin
    host_gnt_o           = '0;
    host_gnt_o[sel_host] = any_gnt;
  end

  always_comb begin
    sel_hit = 1'b0;
    sel_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (addr_decode(AddrWMax'(host_addr_i[sel_host]), AddrWMax'(cfg_device_addr_base[d]),
                      AddrWMax'(cfg_device_addr_mask[d]))) begin
        sel_hit = 1'b1;
        sel_dev = DIW'(d);
      end
    end
  end

  always_comb begin
    device_req_o   = '0;
    device_we_o    = '0;
    device_addr_o  = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (any_gnt && sel_hit) begin
      device_req_o[sel_dev]   = 1'b1;
      device_we_o[sel_dev]    = host_we_i[sel_host];
      device_addr_o[sel_dev]  = host_addr_i[sel_host];
      device_be_o[sel_dev]    = host_be_i[sel_host];
      device_wdata_o[sel_dev] = host_wdata_i[sel_host];
    end
  end

  assign push_ent = '{host: HostIdxW'(sel_host), dev: DevIdxW'(sel_dev), decerr: !sel_hit};

  bus_xbar_rsp_fifo #(
    .Width ($bits(rsp_entry_t)),
    .Depth (MaxOutstanding)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (any_gnt),
    .data_i  (push_ent),
    .pop_i   (rsp_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Only the head device may answer; with nothing outstanding a stray rvalid is simply dropped.
  logic [NrDevices-1:0] rvalid_ok;
  always_comb begin
    rvalid_ok = fifo_empty ? '1 : '0;
    if (!fifo_empty && !head.decerr) rvalid_ok[head_dev] = 1'b1;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) (device_rvalid_i & ~rvalid_ok) == '0);
  assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_cnt <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_bus_xbar_ooo.sv
// Randomised + directed bench for bus_xbar_ooo against a transaction-level queue model.
module tb_bus_xbar_ooo;
  localparam int NH = 2, ND = 3, DW = 32, AW = 32, MO = 4, BW = DW / 8;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [NH-1:0]          host_req_i, host_gnt_o, host_we_i, host_rvalid_o, host_err_o;
  logic [NH-1:0][AW-1:0]  host_addr_i;
  logic [NH-1:0][BW-1:0]  host_be_i;
  logic [NH-1:0][DW-1:0]  host_wdata_i, host_rdata_o;
  logic [ND-1:0]          device_req_o, device_we_o, device_rvalid_i, device_err_i;
  logic [ND-1:0][AW-1:0]  device_addr_o, cfg_base, cfg_mask;
  logic [ND-1:0][BW-1:0]  device_be_o;
  logic [ND-1:0][DW-1:0]  device_wdata_o, device_rdata_i;

  bus_xbar_ooo #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
                 .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_we_o(device_we_o), .device_addr_o(device_addr_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_err_i(device_err_i),
    .device_rdata_i(device_rdata_i),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [AW-1:0] addr; logic we; logic [BW-1:0] be; logic [DW-1:0] wdata; } hreq_t;
  typedef struct { int host; int dev; bit decerr; int due; logic [DW-1:0] data; bit err; } ent_t;

  hreq_t hq [NH][$];
  ent_t  mq [$];
  int    gq[$], gh[$], rq[$], rh[$], re[$];
  int    cyc = 0, lat = 1, rr_ptr = 0, n_chk = 0, n_fail = 0;
  bit    rnd = 0, fix_en = 0;
  logic [DW-1:0] fix_data = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mdec(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++) if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  function automatic hreq_t mk(input logic [AW-1:0] a, input logic we);
    hreq_t r;
    r.addr = a; r.we = we; r.be = '1; r.wdata = $urandom;
    return r;
  endfunction

  function automatic hreq_t rreq();
    hreq_t r;
    logic [AW-1:0] lo;
    lo = $urandom;
    case ($urandom_range(0, 4))
      0:       r.addr = 32'h0010_0000 | (lo & 32'h0000_FFFC);
      1:       r.addr = 32'h8000_0000 | (lo & 32'h0000_0FFC);
      2:       r.addr = 32'h0011_0000 | (lo & 32'h0000_FFFC);
      3:       r.addr = 32'h0010_0000 | (lo & 32'h000F_FFFC);
      default: r.addr = 32'h4000_0000 | (lo & 32'h0000_FFFC);
    endcase
    r.we = 1'($urandom_range(0, 1)); r.be = BW'($urandom); r.wdata = $urandom;
    return r;
  endfunction

  function automatic int pending();
    int n = mq.size();
    for (int h = 0; h < NH; h++) n += hq[h].size();
    return n;
  endfunction

  task automatic drive();
    host_req_i = '0; host_we_i = '0; host_addr_i = '0; host_be_i = '0; host_wdata_i = '0;
    device_rvalid_i = '0; device_err_i = '0; device_rdata_i = '0;
    for (int h = 0; h < NH; h++) begin
      if (rnd && hq[h].size() == 0 && $urandom_range(0, 3) != 0) hq[h].push_back(rreq());
      if (hq[h].size() > 0) begin
        host_req_i[h] = 1'b1; host_addr_i[h] = hq[h][0].addr; host_we_i[h] = hq[h][0].we;
        host_be_i[h] = hq[h][0].be; host_wdata_i[h] = hq[h][0].wdata;
      end
    end
    // Devices answer strictly in global issue order, once their latency has elapsed.
    if (mq.size() > 0 && !mq[0].decerr && cyc >= mq[0].due) begin
      device_rvalid_i[mq[0].dev] = 1'b1;
      device_rdata_i[mq[0].dev]  = mq[0].data;
      device_err_i[mq[0].dev]    = mq[0].err;
    end
  endtask

  task automatic check_cycle();
    bit pop;
    int w, d;
    logic [NH-1:0] eg, ev;
    logic [ND-1:0] ed;
    ent_t e;
    pop = mq.size() > 0 && (mq[0].decerr || cyc >= mq[0].due);
    ev = '0;
    if (pop) ev[mq[0].host] = 1'b1;
    check("host_rvalid", 128'(host_rvalid_o), 128'(ev));
    if (pop) begin
      check("host_rdata", 128'(host_rdata_o[mq[0].host]),
            128'(mq[0].decerr ? {DW{1'b0}} : mq[0].data));
      check("host_err", 128'(host_err_o[mq[0].host]), 128'(mq[0].decerr | mq[0].err));
    end
    w = -1;
    if (mq.size() < MO || pop)
      for (int k = 0; k < NH; k++) begin
`ifdef BUS_XBAR_RR_ARB_EN
        int h = (rr_ptr + k) % NH;
`else
        int h = k;
`endif
        if (w < 0 && hq[h].size() > 0) w = h;
      end
    eg = '0; ed = '0; d = -1;
    if (w >= 0) begin
      eg[w] = 1'b1;
      d = mdec(hq[w][0].addr);
      if (d >= 0) ed[d] = 1'b1;
    end
    check("host_gnt", 128'(host_gnt_o), 128'(eg));
    check("device_req", 128'(device_req_o), 128'(ed));
    if (d >= 0) begin
      check("dev_addr", 128'(device_addr_o[d]), 128'(hq[w][0].addr));
      check("dev_we", 128'(device_we_o[d]), 128'(hq[w][0].we));
      check("dev_be", 128'(device_be_o[d]), 128'(hq[w][0].be));
      check("dev_wdata", 128'(device_wdata_o[d]), 128'(hq[w][0].wdata));
    end
    if (pop) begin
      rq.push_back(cyc); rh.push_back(mq[0].host); re.push_back(int'(mq[0].decerr | mq[0].err));
      void'(mq.pop_front());
    end
    if (w >= 0) begin
      e.host = w; e.dev = d; e.decerr = (d < 0);
      e.due = cyc + ((lat > 0) ? lat : $urandom_range(1, 6));
      e.data = fix_en ? fix_data : DW'($urandom);
      e.err = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      mq.push_back(e);
      void'(hq[w].pop_front());
      rr_ptr = (w + 1) % NH;
      gq.push_back(cyc); gh.push_back(w);
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge clk_i);
    check_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (pending() > 0 && b < 400) begin step(); b++; end
    check({tag, "_drain_timeout"}, 128'(b >= 400), 128'(0));
  endtask

  task automatic clr_logs();
    gq.delete(); gh.delete(); rq.delete(); rh.delete(); re.delete();
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_gnt"}, 128'(host_gnt_o), 128'(0));
    check({tag, "_rvalid"}, 128'(host_rvalid_o), 128'(0));
    check({tag, "_err"}, 128'(host_err_o), 128'(0));
    check({tag, "_rdata"}, 128'(host_rdata_o), 128'(0));
    check({tag, "_dreq"}, 128'(device_req_o), 128'(0));
    check({tag, "_dwe"}, 128'(device_we_o), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFFF_0000;   // RAM
    cfg_base[1] = 32'h8000_0000; cfg_mask[1] = 32'hFFFF_F000;   // GPIO
    cfg_base[2] = 32'h0010_0000; cfg_mask[2] = 32'hFFF0_0000;   // overlaps RAM, loses to it
    drive();
    host_req_i = '1; host_addr_i[0] = 32'h0010_0004; device_rvalid_i = '1;
    #3;
    rst_checks("reset");
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single RAM read, 1-cycle device latency
    clr_logs(); lat = 1; fix_en = 1; fix_data = 32'hDEAD_BEEF;
    hq[0].push_back(mk(32'h0010_0004, 1'b0));
    drain("ram_rd");
    check("ram_rd_lat", 128'(rq[0] - gq[0]), 128'(1));
    fix_en = 0;

    // Unmapped read
    clr_logs();
    hq[0].push_back(mk(32'h4000_0000, 1'b0));
    drain("decerr");
    check("decerr_lat", 128'(rq[0] - gq[0]), 128'(1));
    check("decerr_err", 128'(re[0]), 128'(1));

    // Two hosts contending for 8 cycles
    clr_logs();
    for (int i = 0; i < 8; i++) begin
      hq[0].push_back(mk(32'h0010_0100 + 32'(4 * i), 1'b0));
      hq[1].push_back(mk(32'h8000_0100 + 32'(4 * i), 1'b1));
    end
    repeat (8) step();
    c0 = 0;
    foreach (gh[i]) if (gh[i] == 0) c0++;
`ifdef BUS_XBAR_RR_ARB_EN
    check("contend_host0_grants", 128'(c0), 128'(4));
`else
    check("contend_host0_grants", 128'(c0), 128'(8));
`endif
    drain("contend");

    // Outstanding limit: 5 back-to-back reads, latency 6
    clr_logs(); lat = 6;
    for (int i = 0; i < 5; i++) hq[0].push_back(mk(32'h0010_0200 + 32'(4 * i), 1'b0));
    drain("maxout");
    check("maxout_4th_gnt", 128'(gq[3] - gq[0]), 128'(3));
    check("maxout_5th_gnt", 128'(gq[4]), 128'(rq[0]));
    check("maxout_first_rsp", 128'(rq[0] - gq[0]), 128'(6));

    // Mixed: GPIO write, DECERR, RAM read in consecutive cycles
    clr_logs(); lat = 2;
    hq[0].push_back(mk(32'h8000_0010, 1'b1)); step();
    hq[1].push_back(mk(32'h4000_0000, 1'b0)); step();
    hq[0].push_back(mk(32'h0010_0008, 1'b0));
    drain("mixed");
    check("mixed_rsp0_host", 128'(rh[0]), 128'(0));
    check("mixed_rsp1_host", 128'(rh[1]), 128'(1));
    check("mixed_rsp2_host", 128'(rh[2]), 128'(0));
    check("mixed_rsp1_err", 128'(re[1]), 128'(1));
    check("mixed_rsp2_err", 128'(re[2]), 128'(0));

    // Randomised traffic
    clr_logs(); lat = 0; rnd = 1;
    repeat (500) step();
    rnd = 0;
    drain("random");

    // Async reset with 3 outstanding, then a stray device rvalid
    clr_logs(); lat = 6;
    for (int i = 0; i < 3; i++) hq[0].push_back(mk(32'h0010_0300 + 32'(4 * i), 1'b0));
    repeat (3) step();
    check("rst_outstanding", 128'(mq.size()), 128'(3));
    hq[1].push_back(mk(32'h0010_0400, 1'b0));
    drive();
    device_rvalid_i[0] = 1'b1;
    #2 rst_ni = 1'b0;
    #1 rst_checks("midrst");
    mq.delete(); for (int h = 0; h < NH; h++) hq[h].delete(); rr_ptr = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    drive();
    device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h1234_5678;
    @(negedge clk_i);
    check("stray_rvalid", 128'(host_rvalid_o), 128'(0));
    check("stray_gnt", 128'(host_gnt_o), 128'(0));
    @(posedge clk_i); #1;

    // FIFO must be empty again: 4 immediate grants
    clr_logs();
    for (int i = 0; i < 5; i++) hq[1].push_back(mk(32'h0011_0000 + 32'(4 * i), 1'b0));
    drain("postrst");
    check("postrst_5th_gnt", 128'(gq[4] - gq[0]), 128'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
